// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state encoding and AXI/fetch constants for the fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] INST_FAULT_VAL = 32'h0;
endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: wrapping 64-bit counters of delivered fetches and bus-wait cycles
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        wait_inc,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
);
  always_ff @(posedge clk) begin
    perf_fetch_cnt <= rst ? 64'd0 : perf_fetch_cnt + {63'd0, fetch_inc};
    perf_wait_cnt <= rst ? 64'd0 : perf_wait_cnt + {63'd0, wait_inc};
  end
endmodule

// File: rtl/ifu_axil_fetch.sv
// ifu_axil_fetch: one-outstanding AXI4-Lite instruction fetch to decode; IFU_PERF_CNT_EN adds perf counters
module ifu_axil_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_wait_cnt
`endif
);
  state_t state, state_nxt;
  logic take;
  always_comb begin
    req_ready = state == IDLE || (state == HOLD && inst_ready);
    take = req_valid && req_ready;
    arvalid = state == ADDR;
    rready = state == DATA;
    inst_valid = state == HOLD;
    state_nxt = take ? (pc[1:0] == 2'b00 ? ADDR : HOLD) :
                (state == ADDR && arready) ? DATA :
                (state == DATA && rvalid) ? HOLD :
                (state == HOLD && inst_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr <= '0;
      inst_pc <= '0;
      inst <= '0;
      fault <= 1'b0;
    end else if (take) begin
      araddr <= pc;
      inst_pc <= pc;
      inst <= INST_FAULT_VAL;
      fault <= pc[1:0] != 2'b00;
    end else if (state == DATA && rvalid) begin
      inst <= rresp == AXI_RESP_OKAY ? rdata[31:0] : INST_FAULT_VAL;
      fault <= rresp != AXI_RESP_OKAY;
    end
  end
`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf (
    .clk(clk),
    .rst(rst),
    .fetch_inc(inst_valid && inst_ready),
    .wait_inc(state == ADDR || state == DATA),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_wait_cnt(perf_wait_cnt)
  );
`endif
endmodule

// File: tb/tb_ifu_axil_fetch.sv
// tb_ifu_axil_fetch: random and directed fetches checked against a transaction-level model
module tb_ifu_axil_fetch;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_ready, inst_valid, inst_ready = 1'b0;
  logic [31:0] pc = '0, inst, inst_pc, araddr, rdata = '0;
  logic fault, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0] rresp = '0;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt, perf_wait_cnt, snap_pfc, snap_pwc;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  ifu_axil_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .fault(fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  // model: one transaction at most, tracked by which bus phases it still owes
  bit m_known = 0, m_have = 0, m_need_ar = 0, m_need_r = 0, m_fault = 0, m_any = 0;
  logic [31:0] m_pc = '0, m_inst = '0;
  longint m_fetch = 0, m_wait = 0;
  // slave: single pending read with a response delay
  bit s_pend = 0;
  int s_delay = 0, next_delay = -1, next_resp = -1, ar_hs = 0, r_hs = 0;
  logic [31:0] s_addr = '0;
  logic [1:0] s_resp = '0;
  logic snap_rq, snap_arv, snap_rr, snap_iv, snap_fault;
  logic [31:0] snap_araddr, snap_inst, snap_ipc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] p, input bit ir, input bit ar);
    bit e_iv, e_arv, e_rr, e_rq;
    logic [1:0] t;
    @(negedge clk);
    rst = r; req_valid = rv; pc = p; inst_ready = ir;
    arready = !s_pend && ar;
    rvalid = s_pend && s_delay == 0;
    rresp = rvalid ? s_resp : 2'b00;
    rdata = rvalid ? (s_resp != 2'b00 ? 32'hdead_beef : mem(s_addr)) : 32'h0;
    #1;
    snap_rq = req_ready; snap_arv = arvalid; snap_rr = rready; snap_iv = inst_valid;
    snap_araddr = araddr; snap_inst = inst; snap_ipc = inst_pc; snap_fault = fault;
`ifdef IFU_PERF_CNT_EN
    snap_pfc = perf_fetch_cnt; snap_pwc = perf_wait_cnt;
`endif
    e_iv = m_have && !m_need_ar && !m_need_r;
    e_arv = m_have && m_need_ar;
    e_rr = m_have && !m_need_ar && m_need_r;
    e_rq = !m_have || (e_iv && ir);
    if (m_known) begin
      chk("req_ready", snap_rq, e_rq);
      chk("arvalid", snap_arv, e_arv);
      chk("rready", snap_rr, e_rr);
      chk("inst_valid", snap_iv, e_iv);
      chk("araddr", snap_araddr, m_pc);
      chk("inst_pc", snap_ipc, m_pc);
      if (e_iv || !m_any) begin
        chk("inst", snap_inst, m_inst);
        chk("fault", snap_fault, m_fault);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch_cnt", snap_pfc, m_fetch);
      chk("perf_wait_cnt", snap_pwc, m_wait);
`endif
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_have = 0; m_any = 0; m_pc = '0; m_inst = '0; m_fault = 0;
      m_fetch = 0; m_wait = 0; s_pend = 0;
    end else begin
      if (e_arv || e_rr) m_wait++;
      if (e_iv && ir) begin m_have = 0; m_fetch++; end
      if (e_arv && arready) m_need_ar = 0;
      if (e_rr && rvalid) begin
        m_need_r = 0;
        m_fault = rresp != 2'b00;
        m_inst = m_fault ? 32'h0 : mem(m_pc);
      end
      if (rv && e_rq) begin
        m_have = 1; m_any = 1; m_pc = p;
        m_need_ar = p[1:0] == 2'b00; m_need_r = p[1:0] == 2'b00;
        m_inst = '0; m_fault = p[1:0] != 2'b00;
      end
      if (rvalid && snap_rr) r_hs++;
      if (snap_arv && arready) ar_hs++;
      if (s_pend && rvalid && snap_rr) s_pend = 0;
      else if (s_pend && s_delay > 0) s_delay--;
      if (snap_arv && arready) begin
        t = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
        s_pend = 1; s_addr = snap_araddr;
        s_delay = next_delay >= 0 ? next_delay : $urandom_range(0, 3);
        s_resp = next_resp >= 0 ? 2'(next_resp) : t;
      end
    end
  endtask

  task automatic wait_iv(input bit rv, input logic [31:0] p, input bit ir, input bit ar);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, rv, p, ir, ar);
      seen = snap_iv;
    end
    chk("inst_valid_timeout", seen, 1'b1);
  endtask

  initial begin
    logic [31:0] rp;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset_req_ready", snap_rq, 1'b1);
    chk("reset_inst", snap_inst, 32'h0);
    chk("reset_arvalid", snap_arv, 1'b0);
    next_delay = 0; next_resp = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'h8000_0000, 1, 1);
      chk("zw_req_ready", snap_rq, 1'b1);
      step(0, 0, 0, 1, 1);
      chk("zw_arvalid", snap_arv, 1'b1);
      chk("zw_araddr", snap_araddr, 32'h8000_0000);
      step(0, 0, 0, 1, 1);
      chk("zw_rready", snap_rr, 1'b1);
      step(0, 0, 0, 1, 1);
      chk("zw_inst_valid", snap_iv, 1'b1);
      chk("zw_inst", snap_inst, 32'h0000_0413);
      chk("zw_fault", snap_fault, 1'b0);
    end
    step(0, 0, 0, 1, 1);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_3", snap_pfc, 64'd3);
    chk("perf_wait_6", snap_pwc, 64'd6);
`endif
    ar_hs = 0; r_hs = 0; next_delay = 3;
    step(0, 1, 32'h8000_0008, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("slow_araddr", snap_araddr, 32'h8000_0008);
    step(0, 0, 0, 1, 1);
    wait_iv(0, 0, 1, 0);
    chk("slow_inst", snap_inst, 32'h0000_041b);
    chk("slow_ar_hs", ar_hs, 1);
    chk("slow_r_hs", r_hs, 1);
    step(0, 1, 32'h8000_0002, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("mis_arvalid", snap_arv, 1'b0);
    chk("mis_inst_valid", snap_iv, 1'b1);
    chk("mis_inst", snap_inst, 32'h0);
    chk("mis_fault", snap_fault, 1'b1);
    next_delay = 0; next_resp = 2;
    step(0, 1, 32'h8000_000c, 1, 1);
    wait_iv(0, 0, 1, 1);
    chk("slverr_inst", snap_inst, 32'h0);
    chk("slverr_fault", snap_fault, 1'b1);
    next_resp = 0;
    step(0, 1, 32'h8000_0000, 0, 1);
    wait_iv(1, 32'h8000_0004, 0, 1);
    repeat (4) begin
      step(0, 1, 32'h8000_0004, 0, 1);
      chk("bp_req_ready", snap_rq, 1'b0);
      chk("bp_inst", snap_inst, 32'h0000_0413);
    end
    step(0, 1, 32'h8000_0004, 1, 1);
    chk("zb_req_ready", snap_rq, 1'b1);
    step(0, 0, 0, 1, 1);
    chk("zb_arvalid", snap_arv, 1'b1);
    chk("zb_araddr", snap_araddr, 32'h8000_0004);
    wait_iv(0, 0, 1, 1);
    next_delay = 3;
    step(0, 1, 32'h8000_0010, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rst_in_data", snap_rr, 1'b1);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rst_arvalid", snap_arv, 1'b0);
    chk("rst_rready", snap_rr, 1'b0);
    chk("rst_inst_valid", snap_iv, 1'b0);
    next_delay = -1; next_resp = -1;
    step(0, 1, 32'h8000_0000, 1, 1);
    wait_iv(0, 0, 1, 1);
    chk("post_rst_inst", snap_inst, 32'h0000_0413);
    repeat (3000) begin
      rp = $urandom;
      rp[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, rp,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
